rr_dec_arbiter4: RTL and testbench
==================================

# rr_dec_arbiter4

Four-requester round-robin arbiter that shares one decoded resource between four clients. The winner is held as a 2-bit index plus a valid/enable bit, and decoded into a one-hot grant by 2-to-4 decode with enable. The block sits in front of the decoder datapath and sequences which requester owns it. Grants are held until the owner signals completion or withdraws its request, with an optional watchdog.

## Interface
- HOLD_MAX, 15: maximum cycles a grant may be held when the timeout feature is compiled in (1..255).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  [3:0]  request lines, one per client, level-sensitive.
- done  input  [3:0]  completion pulses, one per client; only the bit of the current owner is observed.
- gnt  output  [3:0]  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  [1:0]  encoded index of current/last owner.
- gnt_valid  output  1  high while a grant is held; acts as the decode enable for `gnt`.
- timeout  output  1  one-cycle pulse on a forced release.

## Operation
- States:
  - IDLE: no owner, `gnt_valid`=0.
  - GRANT: owner = `gnt_idx`, `gnt_valid`=1.
- Priority pointer `ptr[1:0]`. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4. The first set `req` bit wins.
- IDLE -> GRANT: when `req`≠0, load `gnt_idx`=winner and set `gnt_valid`=1.
- GRANT -> IDLE: when `done[gnt_idx]`=1, `req[gnt_idx]`=0, or a timeout occurs. On exit, `gnt_valid`=0 and `ptr`=`gnt_idx`+1 (2-bit wrap, so 3 -> 0). `gnt_idx` keeps its value.
- `gnt` = `gnt_valid` ? one-hot(`gnt_idx`) : 4'b0000. It is derived from registered state only, with no combinational path from `req`.
- `done` bits of non-owners are ignored in all states. All of `done` is ignored in IDLE.
- Simultaneous `done[gnt_idx]` and timeout in the same cycle: this counts as a normal release and `timeout` stays 0.
- New requests raised by non-owners during GRANT have no effect until the return to IDLE.
- Reset values: state IDLE, `ptr`=0, `gnt_idx`=0, `gnt_valid`=0, `gnt`=0, `timeout`=0, hold counter=0.
- Reset asserted mid-grant: all of the above take their reset values at that edge. `ptr` returns to 0; it is not advanced.

## Timing
- Grant latency: `req` seen in IDLE in cycle c -> `gnt` is high in cycle c+1.
- Release latency: release condition in cycle c -> `gnt`=0 in cycle c+1.
- Mandatory one-cycle IDLE bubble between consecutive grants. Back-to-back ownership changes therefore take at least 2 cycles.
- Minimum grant length is 1 cycle.
- With continuous requests from all clients, each client receives a grant at least once every 4 grants.
- `timeout` pulse is registered and coincides with the first cycle of `gnt`=0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter equals HOLD_MAX-1 with no other release, the grant is forced off next cycle, `timeout` pulses for 1 cycle, and `ptr` advances as for a normal release.
- Not defined:
  - No counter is built. A grant is held indefinitely until done/withdraw.
  - `timeout` is tied to 0.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with `req`=4'b1111. Required: `gnt`=0, `gnt_valid`=0, `timeout`=0 during reset. After release, `gnt`=4'b0001 one cycle later.
- Rotation: `req`=4'b1111 held, `done[gnt_idx]` pulsed 1 cycle after each grant. Required grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Skip and wrap: after owner 2 releases, `req`=4'b0001. Required: `gnt`=4'b0001 (search 3 -> 0 wraps), then `ptr`=1 after release.
- Spurious done/withdraw: owner 1 holds; pulse `done`=4'b1101. Required: grant unchanged. Then drop `req[1]`; required `gnt`=0 next cycle.
- Timeout (`ARB_TIMEOUT_EN`, HOLD_MAX=4): `req`=4'b0100 held, no `done`. Required: `gnt`=4'b0100 for exactly 4 cycles, then `gnt`=0 with `timeout`=1 for 1 cycle, then a re-grant to client 2. Without the macro, the grant is held for 100+ cycles and `timeout` stays 0.
- Reset mid-grant: owner 3 active, assert `rst` for 1 cycle. Required: `gnt`=0 next cycle and `ptr`=0; with `req`=4'b1001, the next grant goes to client 0.

Source files
------------

// File: rtl/rr_dec_arbiter4.sv
// rr_dec_arbiter4: four-client round-robin arbiter whose winner is held as a
// 2-bit index plus an enable, then decoded into a registered one-hot grant.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   level-sensitive requests, one per client
//   done[3:0]  completion pulses; only the current owner's bit is observed
//   gnt[3:0]   registered one-hot grant, zero when there is no owner
//   gnt_idx    index of the current (or most recent) owner
//   gnt_valid  grant held; acts as the decode enable for gnt
//   timeout    one-cycle pulse on a forced (watchdog) release
//
// Parameters:
//   HOLD_MAX   longest grant, in cycles, when the watchdog is built (1..255)
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, builds the 8-bit hold counter/watchdog;
//                   otherwise grants last until done/withdraw and timeout=0.

module rr_dec_arbiter4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       rel_norm;
    logic       rel_any;

    // 2-to-4 decode with enable.
    function automatic logic [3:0] dec2to4(input logic en,
                                           input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0000;
        if (en) begin
            unique case (idx)
                2'd0: onehot = 4'b0001;
                2'd1: onehot = 4'b0010;
                2'd2: onehot = 4'b0100;
                2'd3: onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end
        return onehot;
    endfunction

    // Rotating priority search starting at ptr. Walking the offsets from
    // farthest to nearest lets the nearest set request overwrite the rest.
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    // A normal release: owner reports completion or drops its request.
    assign rel_norm = done[gnt_idx] | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic       expire;
    logic       timeout_q;

    assign expire  = (hold_cnt == HOLD_LAST);
    assign rel_any = rel_norm | expire;
    assign timeout = timeout_q;
`else
    assign rel_any = rel_norm;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            gnt       <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        gnt       <= dec2to4(1'b1, win_idx);
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (rel_any) begin
                        // gnt_idx keeps the last owner; ptr moves past it.
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        gnt       <= 4'b0000;
                        ptr       <= gnt_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        // A coincident normal release wins over the watchdog.
                        timeout_q <= expire & ~rel_norm;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the registered outputs.
    a_hold_range: assert property (@(posedge clk)
        (HOLD_MAX >= 1) && (HOLD_MAX <= 255));

    a_gnt_dec: assert property (@(posedge clk) disable iff (rst)
        gnt == dec2to4(gnt_valid, gnt_idx));

    a_valid_state: assert property (@(posedge clk) disable iff (rst)
        gnt_valid == (state == GRANT));

    a_to_idle: assert property (@(posedge clk) disable iff (rst)
        timeout |-> !gnt_valid);

endmodule

// File: tb/tb_rr_dec_arbiter4.sv
// Testbench for rr_dec_arbiter4: directed vectors feed a scoreboard queue,
// and an independent monitor compares each cycle's outputs against it.

module tb_rr_dec_arbiter4;

`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    rr_dec_arbiter4 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       to;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] dn, input logic [3:0] eg,
                        input logic [1:0] ei, input logic et,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        e.gnt  = eg;
        e.idx  = ei;
        e.to   = et;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle presents a result.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (gnt !== mon_e.gnt || gnt_valid !== (|mon_e.gnt) ||
                gnt_idx !== mon_e.idx || timeout !== mon_e.to) begin
                errors++;
                $display("FAIL %s: got gnt=%b vld=%b idx=%0d to=%b, want gnt=%b vld=%b idx=%0d to=%b",
                         mon_e.name, gnt, gnt_valid, gnt_idx, timeout,
                         mon_e.gnt, |mon_e.gnt, mon_e.idx, mon_e.to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles with all requests up.
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "rst0");
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "rst1");
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "first_gnt");

        // Rotation with done one cycle after each grant.
        step(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rot_rel0");
        step(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rot_g1");
        step(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0, "rot_rel1");
        step(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rot_g2");
        step(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0, "rot_rel2");
        step(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rot_g3");
        step(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0, "rot_rel3");
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rot_wrap0");
        step(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rot_rel0b");

        // Skip and wrap: ptr=1, only client 2, then only client 0.
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "skip_g2");
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0, "skip_rel2");
        step(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, "wrap_g0");
        step(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0, "wrap_rel0");
        step(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "ptr_is_1");

        // Spurious done from non-owners, then withdraw by the owner.
        step(0, 4'b1111, 4'b1101, 4'b0010, 2'd1, 0, "spurious_done");
        step(0, 4'b1101, 4'b0000, 4'b0000, 2'd1, 0, "withdraw1");

        // done is ignored while idle; ptr now 2.
        step(0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 0, "idle_done");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "idle_quiet");
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 0, "g3_from_p2");

        // Reset mid-grant, then ptr must be back at 0.
        step(1, 4'b1001, 4'b0000, 4'b0000, 2'd0, 0, "rst_mid");
        step(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 0, "post_rst_g0");
        step(0, 4'b1001, 4'b0001, 4'b0000, 2'd0, 0, "post_rst_rel");
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "idle_again");

        // Long hold by client 2 (ptr=1).
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "hold_g2");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++)
            step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "hold_on");
        step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, "to_pulse");
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "to_regrant");
        for (int i = 0; i < 3; i++)
            step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "hold_on2");
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0, "done_beats_to");
`else
        for (int i = 0; i < 120; i++)
            step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "hold_long");
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0, "hold_rel");
`endif
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "final_idle");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
